// File: rtl/xinput_sched_pkg.sv
// Shared types and sizing helpers for the EP81 interrupt-IN scheduler.
package xinput_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   typedef enum logic {
      GP,
      AUX
   } grant_t;

   localparam int unsigned RPT_BYTES_DEFAULT = 20;
   localparam int unsigned AUX_MAX_DEFAULT   = 8;

   function automatic int unsigned max_bytes(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Byte counter must hold the largest packet length itself, not just length-1.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      return $clog2(max_bytes(a, b) + 1);
   endfunction

endpackage

// File: rtl/ep_byte_serializer.sv
// Shifts a loaded buffer out MSB-byte first onto the EP81 valid/ready handshake.
module ep_byte_serializer #(
   parameter int unsigned BUF_BYTES = 20,
   parameter int unsigned CNT_W     = 5
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   load,
   input  logic [8*BUF_BYTES-1:0] buf_data,
   input  logic [CNT_W-1:0]       len,
   input  logic                   ep_ready,
   output logic [7:0]             ep_data,
   output logic                   ep_valid,
   output logic                   last
);

   logic [8*BUF_BYTES-1:0] shreg;
   logic [CNT_W-1:0]       cnt;

   // Load a packet, then advance one byte per accepted handshake.
   always_ff @(posedge clk) begin
      if (clr) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= buf_data;
         cnt   <= len;
      end else if (ep_valid && ep_ready) begin
         shreg <= shreg << 8;
         cnt   <= cnt - CNT_W'(1);
      end
   end

   assign ep_valid = (cnt != '0);
   assign ep_data  = shreg[8*BUF_BYTES-1 -: 8];
   assign last     = ep_valid && ep_ready && (cnt == CNT_W'(1));

endmodule

// File: rtl/xinput_in_scheduler.sv
// EP81 interrupt-IN scheduler: gamepad change detection and SOF refresh,
// auxiliary report capture, round-robin arbitration and byte serialization.
module xinput_in_scheduler
   import xinput_sched_pkg::*;
#(
   parameter int unsigned RPT_BYTES    = RPT_BYTES_DEFAULT,
   parameter int unsigned AUX_MAX      = AUX_MAX_DEFAULT,
   parameter int unsigned REFRESH_SOFS = 8,
   parameter int unsigned GAP_CYCLES   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   usb_rstn,
   input  logic                   sof,
   input  logic [8*RPT_BYTES-1:0] gp_report,
   input  logic                   gp_strobe,
   input  logic [8*AUX_MAX-1:0]   aux_data,
   input  logic [3:0]             aux_len,
   input  logic                   aux_req,
   output logic                   aux_busy,
   output logic [7:0]             ep_data,
   output logic                   ep_valid,
   input  logic                   ep_ready,
   output logic                   gp_done,
   output logic                   aux_done
);

   localparam int unsigned BUF_BYTES = max_bytes(RPT_BYTES, AUX_MAX);
   localparam int unsigned BUF_W     = 8 * BUF_BYTES;
   localparam int unsigned CNT_W     = cnt_width(RPT_BYTES, AUX_MAX);
   localparam int unsigned REF_W     = (REFRESH_SOFS > 0) ? $clog2(REFRESH_SOFS + 1) : 1;
   localparam int unsigned GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   state_t                 state, state_nxt;
   grant_t                 last_grant;
   logic [8*RPT_BYTES-1:0] gp_next, last_sent;
   logic                   gp_pend, gp_chk, first_after_connect;
   logic [REF_W-1:0]       refresh_cnt;
   logic [8*AUX_MAX-1:0]   aux_buf;
   logic [CNT_W-1:0]       aux_cnt, aux_len_clamped;
   logic                   aux_pend;
   logic [GAP_W-1:0]       gap_cnt;

   logic                   clr, refresh_hit, gp_want, aux_accept;
   logic                   grant_gp, grant_aux, ser_load, ser_last;
   logic [BUF_W-1:0]       ser_buf;
   logic [CNT_W-1:0]       ser_len;

   assign clr = rst || !usb_rstn;

   // A strobe is compared one cycle later against last_sent, so a snapshot
   // captured during a grant is judged against the report just committed.
   assign refresh_hit = (REFRESH_SOFS != 0) && (refresh_cnt == REF_W'(REFRESH_SOFS));
   assign gp_want     = gp_pend || refresh_hit ||
                        (gp_chk && ((gp_next != last_sent) || first_after_connect));

   assign aux_len_clamped = (32'(aux_len) > AUX_MAX) ? CNT_W'(AUX_MAX) : CNT_W'(aux_len);
   assign aux_accept      = aux_req && !aux_busy && (aux_len != '0);

   // State register.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: start on any pending request, close on last byte, then hold the gap.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (gp_want || aux_pend) state_nxt = SEND;
         SEND: if (ser_last) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:  if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: grant selection and serializer load in IDLE.
   always_comb begin
      grant_gp  = 1'b0;
      grant_aux = 1'b0;
      if (state == IDLE) begin
         grant_gp  = gp_want && (!aux_pend || (last_grant == AUX));
         grant_aux = aux_pend && !grant_gp;
      end
      ser_load = grant_gp || grant_aux;
      ser_buf  = grant_gp ? (BUF_W'(gp_next) << (8 * (BUF_BYTES - RPT_BYTES)))
                          : (BUF_W'(aux_buf) << (8 * (BUF_BYTES - AUX_MAX)));
      ser_len  = grant_gp ? CNT_W'(RPT_BYTES) : aux_cnt;
   end

   // Inter-packet gap timer, running only while in GAP.
   always_ff @(posedge clk) begin
      if (clr || state != GAP) gap_cnt <= '0;
      else                     gap_cnt <= gap_cnt + GAP_W'(1);
   end

   // Capture, pending flags, refresh counter, grant history and done pulses.
   always_ff @(posedge clk) begin
      if (clr) begin
         gp_next             <= '0;
         last_sent           <= '0;
         gp_pend             <= 1'b0;
         gp_chk              <= 1'b0;
         first_after_connect <= !rst;
         refresh_cnt         <= '0;
         aux_buf             <= '0;
         aux_cnt             <= '0;
         aux_pend            <= 1'b0;
         aux_busy            <= 1'b0;
         last_grant          <= AUX;
         gp_done             <= 1'b0;
         aux_done            <= 1'b0;
      end else begin
         gp_done  <= ser_last && (last_grant == GP);
         aux_done <= ser_last && (last_grant == AUX);

         if (gp_strobe) gp_next <= gp_report;
         gp_chk <= gp_strobe;
         if (gp_chk) first_after_connect <= 1'b0;

         if (grant_gp) begin
            last_sent   <= gp_next;
            gp_pend     <= 1'b0;
            refresh_cnt <= '0;
            last_grant  <= GP;
         end else begin
            gp_pend <= gp_want;
            if (sof && (refresh_cnt != REF_W'(REFRESH_SOFS)))
               refresh_cnt <= refresh_cnt + REF_W'(1);
         end

         if (grant_aux) last_grant <= AUX;

         if (aux_accept) begin
            aux_buf  <= aux_data;
            aux_cnt  <= aux_len_clamped;
            aux_pend <= 1'b1;
            aux_busy <= 1'b1;
         end else if (ser_last && (last_grant == AUX)) begin
            aux_pend <= 1'b0;
            aux_busy <= 1'b0;
         end
      end
   end

   ep_byte_serializer #(
      .BUF_BYTES (BUF_BYTES),
      .CNT_W     (CNT_W)
   ) u_ser (
      .clk      (clk),
      .clr      (clr),
      .load     (ser_load),
      .buf_data (ser_buf),
      .len      (ser_len),
      .ep_ready (ep_ready),
      .ep_data  (ep_data),
      .ep_valid (ep_valid),
      .last     (ser_last)
   );

endmodule

// File: tb/tb_xinput_in_scheduler.sv
// Scoreboard bench for xinput_in_scheduler: stimulus pushes expected packets,
// a negedge monitor pops and compares every accepted byte and done pulse.
module tb_xinput_in_scheduler;

   localparam int unsigned RPT_BYTES    = 20;
   localparam int unsigned AUX_MAX      = 8;
   localparam int unsigned REFRESH_SOFS = 8;
   localparam int unsigned GAP_CYCLES   = 4;

   logic         clk = 1'b0;
   logic         rst, usb_rstn, sof, gp_strobe, aux_req, ep_ready;
   logic [159:0] gp_report;
   logic [63:0]  aux_data;
   logic [3:0]   aux_len;
   logic         aux_busy, ep_valid, gp_done, aux_done;
   logic [7:0]   ep_data;
   logic         n_aux_busy, n_ep_valid, n_gp_done, n_aux_done;
   logic [7:0]   n_ep_data;

   always #5 clk = ~clk;

   xinput_in_scheduler #(
      .RPT_BYTES(RPT_BYTES), .AUX_MAX(AUX_MAX),
      .REFRESH_SOFS(REFRESH_SOFS), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .usb_rstn(usb_rstn), .sof(sof),
      .gp_report(gp_report), .gp_strobe(gp_strobe),
      .aux_data(aux_data), .aux_len(aux_len), .aux_req(aux_req),
      .aux_busy(aux_busy), .ep_data(ep_data), .ep_valid(ep_valid),
      .ep_ready(ep_ready), .gp_done(gp_done), .aux_done(aux_done)
   );

   // Second instance with refresh disabled; only its ep_valid activity is watched.
   xinput_in_scheduler #(
      .RPT_BYTES(RPT_BYTES), .AUX_MAX(AUX_MAX),
      .REFRESH_SOFS(0), .GAP_CYCLES(GAP_CYCLES)
   ) dut_norf (
      .clk(clk), .rst(rst), .usb_rstn(usb_rstn), .sof(sof),
      .gp_report(gp_report), .gp_strobe(gp_strobe),
      .aux_data(aux_data), .aux_len(aux_len), .aux_req(aux_req),
      .aux_busy(n_aux_busy), .ep_data(n_ep_data), .ep_valid(n_ep_valid),
      .ep_ready(ep_ready), .gp_done(n_gp_done), .aux_done(n_aux_done)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] byte_q[$];
   bit         kind_q[$];   // 0 = gamepad packet, 1 = auxiliary packet

   logic [159:0] m_last;
   bit           m_first, m_lg_aux;
   int           m_sofs;

   bit   rdy_rand = 1'b0;
   logic rstn_edge = 1'b1;
   int   acc_cnt = 0, vcount = 0, n_vcount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [159:0] rnd_rpt();
      logic [159:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) r = {r[127:0], 32'($urandom())};
      return r;
   endfunction

   task automatic push_gp(input logic [159:0] rpt);
      for (int i = 0; i < 20; i++) byte_q.push_back(rpt[159-8*i -: 8]);
      kind_q.push_back(1'b0);
      m_last   = rpt;
      m_lg_aux = 1'b0;
      m_sofs   = 0;
   endtask

   task automatic push_aux(input logic [63:0] d, input int n);
      for (int i = 0; i < n; i++) byte_q.push_back(d[63-8*i -: 8]);
      kind_q.push_back(1'b1);
      m_lg_aux = 1'b1;
   endtask

   // Reference: which requests become packets, and in what order, from an idle start.
   task automatic model_issue(input bit do_gp, input logic [159:0] rpt,
                              input bit do_aux, input logic [63:0] d, input logic [3:0] len);
      bit gp_p, aux_p;
      int n;
      gp_p = do_gp && ((rpt != m_last) || m_first);
      if (do_gp) m_first = 1'b0;
      n     = (int'(len) > int'(AUX_MAX)) ? int'(AUX_MAX) : int'(len);
      aux_p = do_aux && (n != 0);
      if (gp_p && aux_p) begin
         if (m_lg_aux) begin push_gp(rpt); push_aux(d, n); end
         else          begin push_aux(d, n); push_gp(rpt); end
      end else if (gp_p) begin
         push_gp(rpt);
      end else if (aux_p) begin
         push_aux(d, n);
      end
   endtask

   task automatic issue(input bit do_gp, input logic [159:0] rpt, input bit do_aux,
                        input logic [63:0] d, input logic [3:0] len, input bit use_model);
      gp_report = rpt;
      aux_data  = d;
      aux_len   = len;
      gp_strobe = do_gp;
      aux_req   = do_aux;
      @(posedge clk); #1;
      gp_strobe = 1'b0;
      aux_req   = 1'b0;
      if (use_model) model_issue(do_gp, rpt, do_aux, d, len);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((byte_q.size() != 0 || kind_q.size() != 0) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check("idle_timeout", 32'(t < 3000), 32'd1);
      if (t >= 3000) begin
         byte_q.delete();
         kind_q.delete();
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic model_disconnect();
      m_last   = '0;
      m_first  = 1'b1;
      m_lg_aux = 1'b1;
      m_sofs   = 0;
   endtask

   always @(posedge clk) rstn_edge <= usb_rstn;

   // Back-pressure driver: ep_ready low on about 30% of cycles when enabled.
   initial forever begin
      @(posedge clk); #2;
      if (rdy_rand) ep_ready = ($urandom_range(0, 99) >= 30);
   end

   // Monitor: byte/packet scoreboard, hold stability, gap length, done timing.
   initial begin
      bit         prev_v, prev_r, seen, fell;
      logic [7:0] prev_d;
      int         low_run;
      prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; seen = 1'b0; low_run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_v && !prev_r && rstn_edge) begin
               check("hold_valid", 32'(ep_valid), 32'd1);
               check("hold_data", 32'(ep_data), 32'(prev_d));
            end
            fell = prev_v && !ep_valid;
            if (fell || gp_done || aux_done) begin
               if (!rstn_edge) check("disc_no_done", 32'({gp_done, aux_done}), 32'd0);
               else            check("done_on_fall", 32'(gp_done | aux_done), 32'(fell));
            end
            if (gp_done || aux_done) begin
               if (kind_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL done_unexpected: got gp_done=%0d aux_done=%0d expected none", gp_done, aux_done);
               end else begin
                  check("done_kind", 32'(aux_done), 32'(kind_q.pop_front()));
               end
               if (aux_done) check("busy_clear", 32'(aux_busy), 32'd0);
            end
            if (ep_valid && !prev_v && seen)
               check("gap_len", 32'(low_run >= int'(GAP_CYCLES) + 1), 32'd1);
            if (ep_valid && ep_ready) begin
               if (byte_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL byte_unexpected: got 0x%0h expected no byte", ep_data);
               end else begin
                  check("byte", 32'(ep_data), 32'(byte_q.pop_front()));
               end
               acc_cnt++;
            end
            if (ep_valid) begin low_run = 0; seen = 1'b1; vcount++; end
            else low_run++;
            if (n_ep_valid) n_vcount++;
         end
         prev_v = ep_valid;
         prev_r = ep_ready;
         prev_d = ep_data;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [159:0] rpt, r;
      logic [63:0]  d;
      logic [3:0]   l;
      int           base, t, op;

      rst = 1'b1; usb_rstn = 1'b1; sof = 1'b0; gp_strobe = 1'b0; aux_req = 1'b0;
      gp_report = '0; aux_data = '0; aux_len = '0; ep_ready = 1'b1;
      m_last = '0; m_first = 1'b0; m_lg_aux = 1'b1; m_sofs = 0;
      repeat (3) @(posedge clk); #1;
      check("rst_valid", 32'(ep_valid), 32'd0);
      check("rst_data", 32'(ep_data), 32'd0);
      check("rst_busy", 32'(aux_busy), 32'd0);
      check("rst_done", 32'({gp_done, aux_done}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic send with two-cycle latency.
      for (int i = 0; i < 20; i++) rpt[159-8*i -: 8] = 8'(i + 1);
      issue(1'b1, rpt, 1'b0, '0, '0, 1'b1);
      check("lat_t1_valid", 32'(ep_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_t2_valid", 32'(ep_valid), 32'd1);
      check("lat_t2_byte0", 32'(ep_data), 32'h01);
      wait_idle();

      // Unchanged report is not resent.
      base = vcount;
      issue(1'b1, rpt, 1'b0, '0, '0, 1'b1);
      wait_idle();
      check("no_resend", 32'(vcount - base), 32'd0);

      // SOF refresh; the REFRESH_SOFS=0 instance must stay silent.
      base = n_vcount;
      for (int k = 0; k < 8; k++) begin
         sof = 1'b1;
         @(posedge clk); #1;
         sof = 1'b0;
         m_sofs++;
         if (m_sofs == int'(REFRESH_SOFS)) push_gp(m_last);
         repeat (3) @(posedge clk); #1;
      end
      wait_idle();
      check("norf_no_refresh", 32'(n_vcount - base), 32'd0);

      // Disconnect after seven accepted bytes, then resend the identical report.
      r = rnd_rpt();
      base = acc_cnt;
      issue(1'b1, r, 1'b0, '0, '0, 1'b1);
      t = 0;
      while (acc_cnt < base + 7 && t < 200) begin @(posedge clk); #1; t++; end
      check("disc_reach7", 32'(acc_cnt - base), 32'd7);
      usb_rstn = 1'b0;
      ep_ready = 1'b0;
      @(posedge clk); #1;
      check("disc_valid_drop", 32'(ep_valid), 32'd0);
      repeat (4) @(posedge clk); #1;
      check("disc_left", 32'(byte_q.size()), 32'd13);
      byte_q.delete();
      kind_q.delete();
      model_disconnect();
      usb_rstn = 1'b1;
      ep_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      issue(1'b1, r, 1'b0, '0, '0, 1'b1);
      wait_idle();

      // After a reconnect even an all-zero snapshot must be sent.
      usb_rstn = 1'b0;
      repeat (3) @(posedge clk); #1;
      usb_rstn = 1'b1;
      model_disconnect();
      @(posedge clk); #1;
      issue(1'b1, '0, 1'b0, '0, '0, 1'b1);
      wait_idle();

      // Reset, then tie arbitration.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_last = '0; m_first = 1'b0; m_lg_aux = 1'b1; m_sofs = 0;
      @(posedge clk); #1;
      d = {8'hAA, 8'hBB, 8'hCC, 40'($urandom())};
      issue(1'b1, rnd_rpt(), 1'b1, d, 4'd3, 1'b1);
      wait_idle();
      issue(1'b1, rnd_rpt(), 1'b1, d, 4'd3, 1'b1);
      wait_idle();
      issue(1'b1, rnd_rpt(), 1'b0, '0, '0, 1'b1);
      wait_idle();
      issue(1'b1, rnd_rpt(), 1'b1, d, 4'd3, 1'b1);
      wait_idle();

      // Auxiliary length edges.
      issue(1'b0, '0, 1'b1, {$urandom(), $urandom()}, 4'd0, 1'b1);
      check("aux_len0_busy", 32'(aux_busy), 32'd0);
      wait_idle();
      issue(1'b0, '0, 1'b1, {$urandom(), $urandom()}, 4'd12, 1'b1);
      check("aux_len12_busy", 32'(aux_busy), 32'd1);
      wait_idle();
      issue(1'b0, '0, 1'b1, {$urandom(), $urandom()}, 4'd5, 1'b1);
      check("aux_busy_set", 32'(aux_busy), 32'd1);
      issue(1'b0, '0, 1'b1, {$urandom(), $urandom()}, 4'd3, 1'b0);
      wait_idle();

      // Randomized traffic under back-pressure.
      rdy_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         r  = ($urandom_range(0, 2) == 0) ? m_last : rnd_rpt();
         d  = {$urandom(), $urandom()};
         l  = 4'($urandom_range(0, 15));
         case (op)
            0: issue(1'b1, r, 1'b0, d, l, 1'b1);
            1: issue(1'b0, r, 1'b1, d, l, 1'b1);
            2: issue(1'b1, r, 1'b1, d, l, 1'b1);
            default: begin
               l = 4'($urandom_range(1, 15));
               issue(1'b0, r, 1'b1, d, l, 1'b1);
               check("rnd_busy_set", 32'(aux_busy), 32'd1);
               issue(1'b0, r, 1'b1, {$urandom(), $urandom()}, 4'($urandom_range(1, 15)), 1'b0);
            end
         endcase
         wait_idle();
      end
      rdy_rand = 1'b0;
      ep_ready = 1'b1;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
